// File: rtl/kanji_ram_rd_if.sv
// rtl/kanji_ram_rd_if.sv - kanji read stage bus: address-stage/CPU side plus SDRAM req/ack side
interface kanji_ram_rd_if #(
    parameter int ADDR_W = 27
);
    logic              req_cs;
    logic [ADDR_W-1:0] req_addr;
    logic              cpu_wait;
    logic [7:0]        cpu_data;
    logic              data_valid;
    logic              timeout;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;

    modport slave (
        input  req_cs, req_addr, mem_ack, mem_data,
        output cpu_wait, cpu_data, data_valid, timeout, mem_req, mem_addr
    );

    modport master (
        output req_cs, req_addr, mem_ack, mem_data,
        input  cpu_wait, cpu_data, data_valid, timeout, mem_req, mem_addr
    );
endinterface

// File: rtl/kanji_ram_rd.sv
// rtl/kanji_ram_rd.sv - turns one kanji data-port CPU read into one SDRAM req/ack read
// A stuck memory port yields 0xFF after TIMEOUT issue cycles instead of hanging the CPU.
module kanji_ram_rd #(
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    kanji_ram_rd_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TERM_CNT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t            state_q;
    logic              cs_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        cpu_data_q;
    logic              data_valid_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cs_rise;

    // The address stage holds req_cs for the whole CPU read; only its leading edge may start a read.
    assign cs_rise = bus.req_cs & ~cs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cs_q         <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            cpu_data_q   <= 8'hFF;
            data_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            cs_q <= bus.req_cs;
            unique case (state_q)
                IDLE: begin
                    if (cs_rise) begin
                        mem_addr_q <= bus.req_addr;
                        mem_req_q  <= 1'b1;
                        cnt_q      <= '0;
                        timeout_q  <= 1'b0;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Ack is checked first so a reply landing on the terminal count is not lost.
                    if (bus.mem_ack) begin
                        cpu_data_q   <= bus.mem_data;
                        mem_req_q    <= 1'b0;
                        data_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else if ((TIMEOUT != 0) && (cnt_q == TERM_CNT)) begin
                        cpu_data_q   <= 8'hFF;
                        timeout_q    <= 1'b1;
                        mem_req_q    <= 1'b0;
                        data_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        mem_addr_q   <= bus.req_addr;
                        mem_req_q    <= 1'b1;
                        cnt_q        <= '0;
                        timeout_q    <= 1'b0;
                        data_valid_q <= 1'b0;
                        state_q      <= ISSUE;
                    end else if (!bus.req_cs) begin
                        data_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Wait is raised in the strobe cycle itself and released in the ack cycle.
    assign bus.cpu_wait   = ((state_q == IDLE) & cs_rise) | ((state_q == ISSUE) & ~bus.mem_ack);
    assign bus.cpu_data   = cpu_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.timeout    = timeout_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
endmodule

// File: tb/tb_kanji_ram_rd.sv
// tb/tb_kanji_ram_rd.sv - self-checking bench for kanji_ram_rd (TIMEOUT=255 and TIMEOUT=4 instances)
module tb_kanji_ram_rd;
    localparam int AW    = 27;
    localparam int TMO_A = 255;
    localparam int TMO_B = 4;
    localparam logic [AW-1:0] ONES = {AW{1'b1}};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic          cs_s[2];
    logic [AW-1:0] addr_s[2];
    logic          ack_s[2];
    logic [7:0]    data_s[2];
    logic          o_wait[2], o_dv[2], o_to[2], o_req[2];
    logic [7:0]    o_data[2];
    logic [AW-1:0] o_addr[2];

    kanji_ram_rd_if #(.ADDR_W(AW)) bus_a ();
    kanji_ram_rd_if #(.ADDR_W(AW)) bus_b ();

    kanji_ram_rd #(.ADDR_W(AW), .TIMEOUT(TMO_A), .CNT_W(8)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    kanji_ram_rd #(.ADDR_W(AW), .TIMEOUT(TMO_B), .CNT_W(8)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    assign bus_a.req_cs   = cs_s[0];
    assign bus_a.req_addr = addr_s[0];
    assign bus_a.mem_ack  = ack_s[0];
    assign bus_a.mem_data = data_s[0];
    assign bus_b.req_cs   = cs_s[1];
    assign bus_b.req_addr = addr_s[1];
    assign bus_b.mem_ack  = ack_s[1];
    assign bus_b.mem_data = data_s[1];
    assign o_wait[0] = bus_a.cpu_wait;
    assign o_dv[0]   = bus_a.data_valid;
    assign o_to[0]   = bus_a.timeout;
    assign o_req[0]  = bus_a.mem_req;
    assign o_data[0] = bus_a.cpu_data;
    assign o_addr[0] = bus_a.mem_addr;
    assign o_wait[1] = bus_b.cpu_wait;
    assign o_dv[1]   = bus_b.data_valid;
    assign o_to[1]   = bus_b.timeout;
    assign o_req[1]  = bus_b.mem_req;
    assign o_data[1] = bus_b.cpu_data;
    assign o_addr[1] = bus_b.mem_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding read, its age in issue cycles, and the held result.
    bit            m_out[2], m_rdy[2], m_to[2], m_prev[2];
    int            m_age[2];
    logic [AW-1:0] m_addr[2];
    logic [7:0]    m_data[2];

    always @(posedge clk or negedge reset_n) begin : model
        bit rise;
        int lim;
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_out[k] = 0; m_rdy[k] = 0; m_to[k] = 0; m_prev[k] = 0;
                m_age[k] = 0; m_addr[k] = '0; m_data[k] = 8'hFF;
            end else begin
                rise = cs_s[k] && !m_prev[k];
                lim  = (k == 0) ? TMO_A : TMO_B;
                if (m_out[k]) begin
                    if (ack_s[k]) begin
                        m_data[k] = data_s[k]; m_out[k] = 0; m_rdy[k] = 1;
                    end else if (lim != 0 && m_age[k] + 1 == lim) begin
                        m_data[k] = 8'hFF; m_to[k] = 1; m_out[k] = 0; m_rdy[k] = 1;
                    end else begin
                        m_age[k] = m_age[k] + 1;
                    end
                end else if (rise) begin
                    m_out[k] = 1; m_rdy[k] = 0; m_age[k] = 0; m_to[k] = 0; m_addr[k] = addr_s[k];
                end else if (m_rdy[k] && !cs_s[k]) begin
                    m_rdy[k] = 0;
                end
                m_prev[k] = cs_s[k];
            end
        end
    end

    int            req_hi[2], wait_hi[2], req_rise[2];
    logic          mon_prev_req[2];
    logic [AW-1:0] addr_q[$];

    always @(negedge clk) begin : compare
        bit exp_wait;
        for (int k = 0; k < 2; k++) begin
            exp_wait = (!m_out[k] && !m_rdy[k] && cs_s[k] && !m_prev[k]) || (m_out[k] && !ack_s[k]);
            chk("cmp_mem_req", 32'(o_req[k]), 32'(m_out[k]));
            chk("cmp_mem_addr", 32'(o_addr[k]), 32'(m_addr[k]));
            chk("cmp_cpu_data", 32'(o_data[k]), 32'(m_data[k]));
            chk("cmp_data_valid", 32'(o_dv[k]), 32'(m_rdy[k]));
            chk("cmp_timeout", 32'(o_to[k]), 32'(m_to[k]));
            chk("cmp_cpu_wait", 32'(o_wait[k]), 32'(exp_wait));
            if (o_req[k]) req_hi[k]++;
            if (o_wait[k]) wait_hi[k]++;
            if (o_req[k] && !mon_prev_req[k]) begin
                req_rise[k]++;
                if (k == 0) addr_q.push_back(o_addr[k]);
            end
            mon_prev_req[k] = o_req[k];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr(input int k);
        req_hi[k] = 0; wait_hi[k] = 0; req_rise[k] = 0;
        addr_q.delete();
    endtask

    // Strobe, then ack after `dly` non-acked issue cycles; returns in the first DONE cycle.
    task automatic do_read(input int k, input logic [AW-1:0] a, input int dly, input logic [7:0] d);
        cs_s[k] = 1'b1; addr_s[k] = a;
        tick();
        repeat (dly) tick();
        ack_s[k] = 1'b1; data_s[k] = d;
        tick();
        ack_s[k] = 1'b0; data_s[k] = 8'h00;
    endtask

    task automatic drop(input int k);
        cs_s[k] = 1'b0; addr_s[k] = ONES;
        tick();
        tick();
    endtask

    function automatic logic [31:0] qat(input int i);
        return (addr_q.size() > i) ? 32'(addr_q[i]) : 32'hDEADBEEF;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            cs_s[k] = 1'b0; addr_s[k] = ONES; ack_s[k] = 1'b0; data_s[k] = 8'h00;
            mon_prev_req[k] = 1'b0; req_hi[k] = 0; wait_hi[k] = 0; req_rise[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(o_req[0]), 32'd0);
        chk("rst_mem_addr", 32'(o_addr[0]), 32'd0);
        chk("rst_cpu_data", 32'(o_data[0]), 32'hFF);
        chk("rst_data_valid", 32'(o_dv[0]), 32'd0);
        chk("rst_timeout", 32'(o_to[0]), 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: ack three cycles after the first request cycle
        clr(0);
        do_read(0, 27'h0123460, 3, 8'hA5);
        repeat (3) tick();
        chk("t1_req_count", 32'(req_rise[0]), 32'd1);
        chk("t1_mem_addr", qat(0), 32'h0123460);
        chk("t1_wait_cycles", 32'(wait_hi[0]), 32'd4);
        chk("t1_req_cycles", 32'(req_hi[0]), 32'd4);
        chk("t1_cpu_data", 32'(o_data[0]), 32'hA5);
        chk("t1_data_valid", 32'(o_dv[0]), 32'd1);
        chk("t1_timeout", 32'(o_to[0]), 32'd0);
        cs_s[0] = 1'b0; addr_s[0] = ONES;
        chk("t1_dv_exit_cycle", 32'(o_dv[0]), 32'd1);
        tick();
        chk("t1_dv_after_exit", 32'(o_dv[0]), 32'd0);
        tick();

        // 2: long strobe, ack in the first issue cycle
        clr(0);
        do_read(0, 27'h0000777, 0, 8'h5A);
        repeat (18) tick();
        chk("t2_req_count", 32'(req_rise[0]), 32'd1);
        chk("t2_req_cycles", 32'(req_hi[0]), 32'd1);
        chk("t2_cpu_data", 32'(o_data[0]), 32'h5A);
        drop(0);

        // 3: memory never answers
        clr(0);
        cs_s[0] = 1'b1; addr_s[0] = 27'h7FFFFFE;
        for (int i = 0; i < 400 && !o_dv[0]; i++) tick();
        chk("t3_completed", 32'(o_dv[0]), 32'd1);
        chk("t3_req_cycles", 32'(req_hi[0]), 32'd255);
        chk("t3_wait_cycles", 32'(wait_hi[0]), 32'd256);
        chk("t3_cpu_data", 32'(o_data[0]), 32'hFF);
        chk("t3_timeout", 32'(o_to[0]), 32'd1);
        drop(0);
        chk("t3_timeout_sticky", 32'(o_to[0]), 32'd1);
        do_read(0, 27'h0000100, 1, 8'h3C);
        chk("t3_timeout_cleared", 32'(o_to[0]), 32'd0);
        chk("t3_next_data", 32'(o_data[0]), 32'h3C);
        drop(0);

        // 4: TIMEOUT=4, plain timeout then ack exactly on the terminal count
        clr(1);
        cs_s[1] = 1'b1; addr_s[1] = 27'h0004440;
        for (int i = 0; i < 20 && !o_dv[1]; i++) tick();
        chk("t4_to_req_cycles", 32'(req_hi[1]), 32'd4);
        chk("t4_to_flag", 32'(o_to[1]), 32'd1);
        drop(1);
        clr(1);
        do_read(1, 27'h0004444, 3, 8'hC7);
        chk("t4_tie_req_cycles", 32'(req_hi[1]), 32'd4);
        chk("t4_tie_cpu_data", 32'(o_data[1]), 32'hC7);
        chk("t4_tie_timeout", 32'(o_to[1]), 32'd0);
        drop(1);

        // 5: reset in the middle of an issue phase
        cs_s[0] = 1'b1; addr_s[0] = 27'h0005555;
        tick();
        tick();
        chk("t5_req_before", 32'(o_req[0]), 32'd1);
        #2;
        reset_n = 1'b0; cs_s[0] = 1'b0; addr_s[0] = ONES;
        #1;
        chk("t5_async_req", 32'(o_req[0]), 32'd0);
        chk("t5_async_wait", 32'(o_wait[0]), 32'd0);
        chk("t5_async_data", 32'(o_data[0]), 32'hFF);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        ack_s[0] = 1'b1; data_s[0] = 8'h99;
        tick();
        ack_s[0] = 1'b0; data_s[0] = 8'h00;
        tick();
        chk("t5_late_ack_req", 32'(o_req[0]), 32'd0);
        chk("t5_late_ack_data", 32'(o_data[0]), 32'hFF);
        chk("t5_late_ack_dv", 32'(o_dv[0]), 32'd0);
        clr(0);
        do_read(0, 27'h0006666, 2, 8'h44);
        chk("t5_next_count", 32'(req_rise[0]), 32'd1);
        chk("t5_next_data", 32'(o_data[0]), 32'h44);
        drop(0);

        // 6: back-to-back reads with a single low cycle between strobes
        clr(0);
        do_read(0, 27'h0020000, 0, 8'h11);
        chk("t6_first_data", 32'(o_data[0]), 32'h11);
        cs_s[0] = 1'b0; addr_s[0] = ONES;
        tick();
        do_read(0, 27'h0020001, 0, 8'h22);
        chk("t6_second_data", 32'(o_data[0]), 32'h22);
        chk("t6_req_count", 32'(req_rise[0]), 32'd2);
        chk("t6_addr0", qat(0), 32'h0020000);
        chk("t6_addr1", qat(1), 32'h0020001);
        drop(0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/kanji_ram_rd.md
Name: kanji_ram_rd

Overview:
- Read-transaction stage directly downstream of the kanji font-ROM address generator.
- Takes its ram_cs/ram_addr pair, which is combinational and held while the CPU I/O read lasts, and converts it into one req/ack transaction on the SDRAM port.
- Returns the font byte to the CPU data mux and stretches the CPU cycle through a wait line until data arrives.
- Guarantees exactly one memory read per CPU I/O read. A stuck memory port returns 0xFF after a timeout instead of hanging the bus.

Parameters:
ADDR_W, 27, width of the memory byte address.
TIMEOUT, 255, maximum cycles in ISSUE before the read aborts with 0xFF; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
clk  in  1  system clock (same clock as cpu_bus.clk).
reset_n  in  1  asynchronous, active-low reset.
req_cs  in  1  read select from the kanji address stage; high for the duration of a kanji data-port read.
req_addr  in  ADDR_W  byte address; meaningful only while req_cs=1 (all-ones otherwise).
cpu_wait  out  1  stretches the CPU cycle while a read is outstanding.
cpu_data  out  8  last returned byte; stable outside ISSUE.
data_valid  out  1  high in DONE (byte is ready for the CPU data mux).
timeout  out  1  sticky: set when a read aborts on timeout; cleared by the next capture.
mem_req  out  1  memory read request; held until acknowledged.
mem_addr  out  ADDR_W  latched read address; stable while mem_req=1.
mem_ack  in  1  single-cycle acknowledge; mem_data is valid in the same cycle.
mem_data  in  8  read data.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; mem_req=0; mem_addr=0; cpu_data=8'hFF; data_valid=0; timeout=0; counter=0; cs_d=0. Reset mid-transaction drops mem_req immediately; a late mem_ack after reset release is ignored.
- Edge detect: cs_d registers req_cs every cycle; cs_rise = req_cs & ~cs_d. Only cs_rise starts a read, so a long req_cs never produces a second read.
- States IDLE, ISSUE, DONE:
  - IDLE: on cs_rise, mem_addr<=req_addr, mem_req<=1, counter<=0, timeout<=0, go to ISSUE. A cs_rise is also accepted in DONE when req_cs fell and rose again on consecutive cycles.
  - ISSUE: mem_req=1 and mem_addr held; counter increments every cycle.
    - mem_ack=1: cpu_data<=mem_data, mem_req<=0, go to DONE. Ack is accepted from the first ISSUE cycle.
    - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: cpu_data<=8'hFF, timeout<=1, mem_req<=0, go to DONE. Ack and timeout in the same cycle: ack wins.
  - DONE: data_valid=1. If req_cs=0, go to IDLE; data_valid stays high for this one exit cycle and is 0 from IDLE onward.
- req_cs dropping during ISSUE (aborted access): the transaction still completes; DONE then exits the next cycle because req_cs=0. mem_req is never withdrawn before ack or timeout.
- cpu_wait is combinational: (state==IDLE & cs_rise) | (state==ISSUE & ~mem_ack). There is no gap cycle between the CPU strobe and wait. Wait drops in the ack cycle, so the CPU samples cpu_data one cycle later, when it is registered.
- mem_ack while not in ISSUE: ignored, no state change.
- mem_req is registered; the first request cycle is the cycle after cs_rise.
- Latency with a zero-wait memory:
  - cs_rise at cycle 0 → mem_req at 1 → ack at 1 → data_valid and cpu_data at 2.
  - cpu_wait is high in cycles 0–1 minus the ack cycle, i.e. high only in cycle 0.
- Counter saturates; no wrap inside ISSUE.

Test Plan:
1. req_cs rises with req_addr=27'h0123460, mem_ack returns 8'hA5 three cycles after mem_req → exactly one mem_req pulse train with mem_addr=27'h0123460; cpu_wait high 4 cycles; cpu_data=8'hA5; data_valid until req_cs falls; timeout=0.
2. req_cs held 20 cycles, ack on the first ISSUE cycle → a single transaction; mem_req high exactly 1 cycle; no second request while req_cs stays high.
3. mem_ack never asserted, TIMEOUT=255 → mem_req drops after exactly 255 ISSUE cycles; cpu_data=8'hFF; timeout=1. The next read, acked with 8'h3C, clears timeout.
4. mem_ack and the timeout terminal count in the same cycle (TIMEOUT=4, ack on 4th cycle) → cpu_data=mem_data; timeout=0.
5. reset_n pulsed low during ISSUE → mem_req=0 and cpu_wait=0 asynchronously; cpu_data=8'hFF; a mem_ack one cycle after release causes no change; the following req_cs rise starts a normal read.
6. Two back-to-back reads (req_cs low for 1 cycle between) at addresses 27'h20000/27'h20001 acked with 8'h11/8'h22 → two transactions, in order, with correct addresses and cpu_data sequence 8'h11 then 8'h22.
